// File: rtl/sd_cmd_serializer_pkg.sv
// Shared SD command-path definitions.
// Frame geometry, CRC7 polynomial, FSM state type and header packing.
package sd_cmd_serializer_pkg;

    localparam int FRAME_BITS = 48;
    localparam int HDR_BITS   = 40;
    localparam int CRC_BITS   = 7;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CRC,
        ST_END,
        ST_GAP
    } sd_state_e;

    // Start bit 0, transmission bit 1, index, argument.
    function automatic logic [HDR_BITS-1:0] build_hdr(
        input logic [5:0]  idx,
        input logic [31:0] arg
    );
        return {2'b01, idx, arg};
    endfunction

endpackage

// File: rtl/sd_cmd_serializer_crc7.sv
// Bit-serial CRC7 (x^7+x^3+1) remainder register.
// Ports: clk, rst_n, clear, enable, data, rem[6:0].
module crc7_serial
    import sd_cmd_serializer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       data,
    output logic [6:0] rem
);

    logic       fb;
    logic [6:0] rem_nxt;

    assign fb      = data ^ rem[6];
    assign rem_nxt = {rem[5:0], 1'b0} ^ ({7{fb}} & CRC7_POLY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
        end else if (clear) begin
            rem <= '0;
        end else if (enable) begin
            rem <= rem_nxt;
        end
    end

endmodule

// File: rtl/sd_cmd_serializer.sv
// SD CMD-line serializer: 48-bit frame with CRC7, end bit and Ncc gap.
// Ports: clk, rst_n, bit_en, cmd_valid/ready/index/arg, sd_cmd_out/oe, crc_out, done.
module sd_cmd_serializer
    import sd_cmd_serializer_pkg::*;
#(
    parameter int GAP_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_en,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic [6:0]  crc_out,
    output logic        done
);

    localparam logic [5:0] HDR_LAST = 6'(HDR_BITS - 1);
    localparam logic [5:0] CRC_LAST = 6'(CRC_BITS - 1);
    localparam logic [7:0] GAP_LAST = 8'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    sd_state_e             state;
    sd_state_e             state_nxt;
    logic [5:0]            bit_cnt;
    logic [7:0]            gap_cnt;
    logic [HDR_BITS-1:0]   hdr_sr;
    logic [6:0]            crc_rem;
    logic [6:0]            crc_q;
    logic                  ready_en;
    logic                  accept;
    logic [2:0]            crc_idx;

    assign accept  = cmd_valid && cmd_ready;
    assign crc_idx = 3'd6 - bit_cnt[2:0];
    assign crc_out = crc_q;

    crc7_serial u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (bit_en && (state == ST_HDR)),
        .data   (hdr_sr[HDR_BITS-1]),
        .rem    (crc_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept) state_nxt = ST_HDR;
            ST_HDR:  if (bit_en && bit_cnt == HDR_LAST) state_nxt = ST_CRC;
            ST_CRC:  if (bit_en && bit_cnt == CRC_LAST) state_nxt = ST_END;
            ST_END:  if (bit_en) state_nxt = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:  if (bit_en && gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ready_en keeps cmd_ready low while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            hdr_sr   <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            crc_q    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                hdr_sr  <= build_hdr(cmd_index, cmd_arg);
                bit_cnt <= '0;
                gap_cnt <= '0;
            end else if (bit_en) begin
                case (state)
                    ST_HDR: begin
                        hdr_sr  <= {hdr_sr[HDR_BITS-2:0], 1'b0};
                        bit_cnt <= (bit_cnt == HDR_LAST) ? 6'd0 : bit_cnt + 6'd1;
                    end
                    ST_CRC: begin
                        if (bit_cnt == CRC_LAST) begin
                            bit_cnt <= '0;
                            crc_q   <= crc_rem;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    ST_END: begin
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                    end
                    ST_GAP: begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cmd_ready  = 1'b0;
        sd_cmd_oe  = 1'b1;
        sd_cmd_out = 1'b1;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                sd_cmd_oe = 1'b0;
                cmd_ready = ready_en;
            end
            ST_HDR:  sd_cmd_out = hdr_sr[HDR_BITS-1];
            ST_CRC:  sd_cmd_out = crc_rem[crc_idx];
            ST_END:  done = bit_en;
            ST_GAP:  ;
            default: sd_cmd_oe = 1'b0;
        endcase
    end

endmodule
